// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

  // Sequencer states; exposed on the debug port of the top.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_EXC   = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Operation type; the encoding doubles as the HI/LO mux select value.
  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  // Default number of WAIT cycles before a unit is declared hung.
  localparam int TIMEOUT_DEFAULT = 48;

  // Watchdog counter width; wide enough for TIMEOUT up to 255.
  localparam int CNT_W = 8;

endpackage

// File: rtl/muldiv_seq_if.sv
// Signal bundle between the control unit, the mult/div units and the
// HI/LO write port of the sequencer.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; req_op is only meaningful in that cycle.
// req_ready is high only while the sequencer is idle, and a req_valid
// seen at any other time is dropped rather than queued.
interface muldiv_seq_if;
  logic req_valid;
  logic req_op;
  logic req_ready;
  logic flush;
  logic start_mult;
  logic start_div;
  logic mult_done;
  logic div_done;
  logic div_zero;
  logic sel_hi;
  logic sel_lo;
  logic wr_hi;
  logic wr_lo;
  logic busy;
  logic done;
  logic exc_div0;
  logic err_timeout;

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, flush, mult_done, div_done, div_zero,
    output req_ready, start_mult, start_div, sel_hi, sel_lo,
           wr_hi, wr_lo, busy, done, exc_div0, err_timeout
  );

  // Control unit / execution units side.
  modport master (
    output req_valid, req_op, flush, mult_done, div_done, div_zero,
    input  req_ready, start_mult, start_div, sel_hi, sel_lo,
           wr_hi, wr_lo, busy, done, exc_div0, err_timeout
  );
endinterface

// File: rtl/muldiv_wdog.sv
// Watchdog counter for the WAIT state: cleared on start, counts while
// enabled, saturates at TIMEOUT and flags the last allowed cycle.
module muldiv_wdog
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count WAIT cycles; clear has priority over counting, and the count holds at TIMEOUT.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == CNT_LAST);

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer that launches a multiply or divide, waits for the unit,
// and then writes HI/LO or reports divide-by-zero / hang.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  muldiv_seq_if.slave  bus,
  output state_t       o_state
);

  state_t r_state;
  op_t    r_op;
  state_t w_state_nxt;
  op_t    w_op_nxt;
  logic   w_tc;
  logic   w_unit_done;
  logic   w_unit_zero;

  logic   r_req_ready;
  logic   r_busy;
  logic   r_start_mult;
  logic   r_start_div;
  logic   r_sel;
  logic   r_wr;
  logic   r_done;
  logic   r_exc;
  logic   r_err;

  muldiv_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (r_state == ST_START),
    .i_enable (r_state == ST_WAIT),
    .o_tc     (w_tc)
  );

  // Only the flags of the unit selected by op_q are looked at.
  assign w_unit_done = (r_op == OP_MULT) ? bus.mult_done : bus.div_done;
  assign w_unit_zero = (r_op == OP_DIV) && bus.div_zero;

  // Next-state and next-op selection; WAIT exits in priority order.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_op_nxt    = op_t'(bus.req_op);
          w_state_nxt = ST_START;
        end
      end
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.flush)       w_state_nxt = ST_IDLE;
        else if (w_unit_zero) w_state_nxt = ST_EXC;
        else if (w_unit_done) w_state_nxt = ST_WRITE;
        else if (w_tc)        w_state_nxt = ST_ERR;
      end
      ST_WRITE: w_state_nxt = ST_IDLE;
      ST_EXC:   w_state_nxt = ST_IDLE;
      ST_ERR:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, op and registered outputs, each output decoded from the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_MULT;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_start_mult <= 1'b0;
      r_start_div  <= 1'b0;
      r_sel        <= 1'b0;
      r_wr         <= 1'b0;
      r_done       <= 1'b0;
      r_exc        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_req_ready  <= (w_state_nxt == ST_IDLE);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_start_mult <= (w_state_nxt == ST_START) && (w_op_nxt == OP_MULT);
      r_start_div  <= (w_state_nxt == ST_START) && (w_op_nxt == OP_DIV);
      r_sel        <= (w_op_nxt == OP_DIV);
      r_wr         <= (w_state_nxt == ST_WRITE);
      r_done       <= (w_state_nxt == ST_WRITE);
      r_exc        <= (w_state_nxt == ST_EXC);
      r_err        <= (w_state_nxt == ST_ERR);
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.busy        = r_busy;
  assign bus.start_mult  = r_start_mult;
  assign bus.start_div   = r_start_div;
  assign bus.sel_hi      = r_sel;
  assign bus.sel_lo      = r_sel;
  assign bus.wr_hi       = r_wr;
  assign bus.wr_lo       = r_wr;
  assign bus.done        = r_done;
  assign bus.exc_div0    = r_exc;
  assign bus.err_timeout = r_err;
  assign o_state         = r_state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for the mult/div sequencer.
// Output vector bit order: [10] req_ready [9] busy [8] start_mult
// [7] start_div [6] sel_hi [5] sel_lo [4] wr_hi [3] wr_lo [2] done
// [1] exc_div0 [0] err_timeout.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic   clock;
  logic   reset;
  state_t dbg_state;
  int     n_assert;
  int     n_fail;
  int     n_cyc;
  int     t_acc0;
  int     t_acc1;

  muldiv_seq_if bus ();

  muldiv_seq #(.TIMEOUT(48)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // Clock / reset block.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
    n_cyc++;
  endtask

  function automatic logic [10:0] outs();
    return {bus.req_ready, bus.busy, bus.start_mult, bus.start_div,
            bus.sel_hi, bus.sel_lo, bus.wr_hi, bus.wr_lo,
            bus.done, bus.exc_div0, bus.err_timeout};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected output vectors.
  localparam logic [15:0] V_IDLE0  = 16'h400; // idle, sel = mult
  localparam logic [15:0] V_IDLE1  = 16'h460; // idle, sel = div
  localparam logic [15:0] V_STM    = 16'h300; // start_mult
  localparam logic [15:0] V_STD    = 16'h2E0; // start_div, sel = div
  localparam logic [15:0] V_WAITM  = 16'h200;
  localparam logic [15:0] V_WAITD  = 16'h260;
  localparam logic [15:0] V_WRM    = 16'h21C; // write, sel = mult
  localparam logic [15:0] V_WRD    = 16'h27C; // write, sel = div
  localparam logic [15:0] V_EXC    = 16'h262;
  localparam logic [15:0] V_ERR    = 16'h261;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    n_cyc    = 0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.flush     = 1'b0;
    bus.mult_done = 1'b0;
    bus.div_done  = 1'b0;
    bus.div_zero  = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("reset_outs", 16'(outs()), V_IDLE0);
    chk("reset_state", 16'(dbg_state), 16'(ST_IDLE));
    reset = 1'b0;
    tick();
    chk("idle_hold", 16'(outs()), V_IDLE0);

    // MULT, mult_done raised 33 cycles after start_mult.
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    tick();
    chk("mult_start", 16'(outs()), V_STM);
    bus.req_valid = 1'b0;
    tick();
    for (int i = 1; i <= 32; i++) begin
      chk($sformatf("mult_wait%0d", i), 16'(outs()), V_WAITM);
      tick();
    end
    bus.mult_done = 1'b1;
    chk("mult_wait33", 16'(outs()), V_WAITM);
    tick();
    bus.mult_done = 1'b0;
    chk("mult_write", 16'(outs()), V_WRM);
    tick();
    chk("mult_ready", 16'(outs()), V_IDLE0);

    // DIV with div_zero and div_done together -> exception, no write.
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    tick();
    chk("div0_start", 16'(outs()), V_STD);
    bus.req_valid = 1'b0;
    tick();
    chk("div0_wait", 16'(outs()), V_WAITD);
    bus.div_zero = 1'b1;
    bus.div_done = 1'b1;
    tick();
    bus.div_zero = 1'b0;
    bus.div_done = 1'b0;
    chk("div0_exc", 16'(outs()), V_EXC);
    chk("div0_exc_state", 16'(dbg_state), 16'(ST_EXC));
    tick();
    chk("div0_idle", 16'(outs()), V_IDLE1);

    // DIV timeout with mult_done held high: err 48 cycles after entering WAIT.
    bus.mult_done = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    tick();
    chk("to_start", 16'(outs()), V_STD);
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 48; i++) begin
      chk($sformatf("to_wait%0d", i), 16'(outs()), V_WAITD);
      tick();
    end
    chk("to_err", 16'(outs()), V_ERR);
    bus.mult_done = 1'b0;
    tick();
    chk("to_idle", 16'(outs()), V_IDLE1);

    // Flush in WAIT cycle 5 of a MULT, then immediate re-accept.
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    tick();
    chk("fl_start", 16'(outs()), V_STM);
    bus.req_valid = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("fl_wait%0d", i), 16'(outs()), V_WAITM);
      tick();
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_idle", 16'(outs()), V_IDLE0);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("fl_reaccept", 16'(outs()), V_STM);
    // Flush during START is ignored.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_start_ign", 16'(outs()), V_WAITM);
    bus.mult_done = 1'b1;
    tick();
    bus.mult_done = 1'b0;
    chk("fl_write", 16'(outs()), V_WRM);
    tick();
    chk("fl_idle2", 16'(outs()), V_IDLE0);

    // Reset pulse in WAIT of a DIV, then a late div_done.
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("rst_start", 16'(outs()), V_STD);
    tick();
    tick();
    chk("rst_wait", 16'(outs()), V_WAITD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_idle", 16'(outs()), V_IDLE0);
    bus.div_done = 1'b1;
    tick();
    bus.div_done = 1'b0;
    chk("rst_nowrite", 16'(outs()), V_IDLE0);

    // Back-to-back MULT then DIV, units done after 1 cycle; req_valid held.
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    tick();
    t_acc0 = n_cyc;
    chk("b2b_start_m", 16'(outs()), V_STM);
    bus.req_op = 1'b1;
    tick();
    chk("b2b_wait_m", 16'(outs()), V_WAITM);
    bus.mult_done = 1'b1;
    tick();
    bus.mult_done = 1'b0;
    chk("b2b_write_m", 16'(outs()), V_WRM);
    tick();
    chk("b2b_idle", 16'(outs()), V_IDLE0);
    tick();
    t_acc1 = n_cyc;
    bus.req_valid = 1'b0;
    chk("b2b_start_d", 16'(outs()), V_STD);
    chk("b2b_spacing", 16'(t_acc1 - t_acc0), 16'd4);
    tick();
    chk("b2b_wait_d", 16'(outs()), V_WAITD);
    bus.div_done = 1'b1;
    tick();
    bus.div_done = 1'b0;
    chk("b2b_write_d", 16'(outs()), V_WRD);
    tick();
    chk("b2b_idle_d", 16'(outs()), V_IDLE1);
    chk("b2b_state", 16'(dbg_state), 16'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter TIMEOUT, default 48, maximum WAIT-state cycles before a unit is declared hung (range 2..255).
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  control unit requests a mult/div operation.
REQ-005 req_op  in  1  0 = MULT, 1 = DIV; sampled only on acceptance.
REQ-006 req_ready  out  1  high only in IDLE; acceptance = req_valid & req_ready.
REQ-007 flush  in  1  abort the in-flight operation.
REQ-008 start_mult / start_div  out  1 each  one-cycle start pulses to the mult and div units.
REQ-009 mult_done, div_done, div_zero  in  1 each  completion and divide-by-zero flags from the units.
REQ-010 sel_hi / sel_lo  out  1 each  HI/LO source mux selects: 0 = mult, 1 = div.
REQ-011 wr_hi / wr_lo  out  1 each  HI/LO register load enables.
REQ-012 busy  out  1  high in every state except IDLE; stalls the main control FSM.
REQ-013 done / exc_div0 / err_timeout  out  1 each  one-cycle completion / divide-by-zero / hang status pulses.

Function
REQ-014 States: IDLE, START, WAIT, WRITE, EXC, ERR, encoded as an enum.
REQ-015 IDLE: on acceptance, latch req_op into op_q and go to START; otherwise remain in IDLE.
REQ-016 START (exactly 1 cycle): assert start_mult if op_q = MULT, or start_div if op_q = DIV; clear the cycle counter; go to WAIT.
REQ-017 WAIT: the counter increments by 1 each cycle and saturates at TIMEOUT.
REQ-018 WAIT exit priority, highest first:
- flush -> IDLE;
- op_q = DIV & div_zero -> EXC;
- op_q = MULT & mult_done, or op_q = DIV & div_done -> WRITE;
- counter = TIMEOUT-1 -> ERR.
REQ-019 Done/zero flags from the unit not selected by op_q are ignored.
REQ-020 WRITE (1 cycle): wr_hi = wr_lo = 1, sel_hi = sel_lo = op_q, done = 1; go to IDLE.
REQ-021 WRITE latency: unit done sampled at edge k -> HI/LO load at edge k+1 -> req_ready high at edge k+2.
REQ-022 EXC (1 cycle): exc_div0 = 1, no HI/LO write; go to IDLE.
REQ-023 ERR (1 cycle): err_timeout = 1, no HI/LO write; go to IDLE.
REQ-024 flush in START, WRITE, EXC or ERR has no effect; those states always complete.
REQ-025 req_valid outside IDLE is ignored and never queued.
REQ-026 sel_hi/sel_lo equal op_q in all states; wr_* and the start pulses are 0 outside the states named above.
REQ-027 A new request can be accepted in the first cycle back in IDLE, giving a back-to-back minimum of 4 cycles per operation.

Reset
REQ-028 While reset is high at an edge:
- state <- IDLE; op_q <- 0; counter <- 0;
- all outputs 0 except req_ready = 1.
REQ-029 Reset has priority over every input, including mid-operation; any in-flight result is discarded with no HI/LO write.

Structure
REQ-030 Shared package muldiv_pkg holds: the state enum, the op enum (OP_MULT = 0, OP_DIV = 1), and the TIMEOUT default constant.
REQ-031 The watchdog is one sub-module, muldiv_wdog (clear, enable, terminal-count output); all other logic is inline.
REQ-032 All outputs are registered or decoded from state plus op_q only; no input-to-output combinational paths.

Verification
REQ-033 MULT, mult_done raised 33 cycles after start_mult:
- wr_hi, wr_lo and done pulse once, with sel = 0, one cycle later;
- req_ready returns on the following cycle.
REQ-034 DIV with div_zero and div_done both high in the same WAIT cycle -> exc_div0 pulses; no wr_hi/wr_lo; done stays 0.
REQ-035 DIV, with mult_done held high throughout and div_done never asserted, TIMEOUT = 48 -> err_timeout pulses exactly 48 cycles after entering WAIT; no write.
REQ-036 flush asserted in WAIT cycle 5 of a MULT -> IDLE on the next edge; no pulses; next request accepted immediately.
REQ-037 reset pulsed for 1 cycle in WAIT of a DIV, then div_done asserted -> no write and no done; req_ready = 1 after the reset edge.
REQ-038 Back-to-back MULT then DIV with units done at 1 cycle each:
- exactly 4 cycles from acceptance to acceptance;
- sel = 0, then sel = 1, on the respective writes.
